alu_control_seq: RTL and testbench
==================================

// Module: alu_control_seq
// PURPOSE
//  Registered ID/EX ALU controller, successor to the combinational ALU decoder. Decodes
//  ALUOp/funct3/funct7 into the 4-bit ALU Operation, adds RV32M decode, and sequences a
//  fixed-latency multi-cycle MUL/DIV unit. Stalls the front end while that unit is busy.
//  Sits between the main Controller (ID stage) and the ALU/MDU (EX stage).
// PARAMETERS
//  M_EXT       1   1: decode RV32M (funct7=0000001, R-type); 0: such encodings flagged illegal
//  MUL_CYCLES  2   EX cycles for MUL/MULH/MULHSU/MULHU (funct3[2]=0), >=1
//  DIV_CYCLES  33  EX cycles for DIV/DIVU/REM/REMU (funct3[2]=1), >=1
//  CNT_W       $clog2(max(MUL_CYCLES,DIV_CYCLES)+1)  busy-counter width (derived)
// PORTS
//  clk           in   1  clock, rising edge
//  reset         in   1  synchronous, active-high
//  id_valid      in   1  ID holds a valid instruction
//  id_rtype      in   1  instruction is R-type (funct7 is real, not immediate bits)
//  ALUOp         in   2  00 LW/SW/AUIPC/JALR, 01 branch, 10 R/I-type, 11 JAL/LUI
//  Funct7        in   7  instr[31:25]
//  Funct3        in   3  instr[14:12]
//  flush         in   1  kill EX contents (branch taken / trap)
//  stall         out  1  hold ID/IF; combinational from state
//  ex_valid      out  1  EX stage holds a valid decoded op
//  Operation     out  4  registered ALU operation select
//  ex_is_mdu     out  1  EX op is an RV32M op (writeback selects MDU result)
//  mdu_op        out  3  registered Funct3 for the MDU
//  mdu_start     out  1  one-cycle pulse launching the MDU
//  mdu_abort     out  1  one-cycle pulse when flush kills a busy MDU op
//  illegal       out  1  registered: EX op is an unsupported encoding
// BEHAVIOUR
//  - Operation encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101,
//    SUB 0110, SRA 0111, BEQ 1000, BNE 1001, PASS-B 1010 (ALUOp=11), SLT/BLT 1100,
//    BGE 1101, SLTU/BLTU 1110, BGEU 1111. ALUOp=00 -> ADD.
//  - SUB only when ALUOp=10, Funct3=000, Funct7=0100000 AND id_rtype=1 (ADDI never SUB).
//  - ALUOp=10, Funct3=101, Funct7 not in {0000000,0100000}: illegal=1, Operation=ADD.
//  - ALUOp=01, Funct3 in {010,011}: illegal=1, Operation=BEQ.
//  - M op = M_EXT & id_rtype & ALUOp=10 & Funct7=0000001; with M_EXT=0 -> illegal=1, ADD.
//  - Latency: decode registered; visible on outputs 1 cycle after capture.
//  - Capture when id_valid & !stall & !flush; else ex_valid<=0 (bubble), other regs hold.
//  - FSM IDLE/BUSY. IDLE + captured M op: ex_is_mdu=1, mdu_start=1 next cycle, ->BUSY,
//    cnt<=N-1 (N=MUL_CYCLES or DIV_CYCLES). BUSY: cnt decrements each cycle;
//    stall = (state==BUSY) & (cnt!=0); at cnt==0 stall drops, op retires, next ID op may
//    be captured that same cycle (back-to-back M ops allowed), else ->IDLE.
//  - N=1: stall never asserts; MDU op behaves like a single-cycle ALU op.
//  - flush has priority over capture: ex_valid<=0, ->IDLE, cnt<=0; if state was BUSY with
//    cnt!=0, mdu_abort=1 next cycle. flush and cnt==0 together: no abort.
//  - reset: state IDLE, cnt 0, ex_valid 0, Operation 0010, mdu_op 0, ex_is_mdu 0,
//    mdu_start 0, mdu_abort 0, illegal 0, stall 0. Reset mid-BUSY: no abort pulse.
// STRUCTURE
//  - Package alu_ctrl_pkg: localparams for the 4-bit Operation codes, ALUOp codes,
//    FUNCT7_BASE/ALT/MULDIV; FSM state typedef.
//  - Sub-module alu_op_decode: pure combinational ALUOp/Funct3/Funct7/id_rtype ->
//    {Operation, is_mdu, illegal}. Top holds stage regs, FSM and busy counter.
// TESTING
//  1 ALUOp=10,F3=000,F7=0100000, rtype=1 -> Operation=0110; same with rtype=0 -> 0010.
//  2 All 6 legal branch funct3 values, ALUOp=01 -> codes per table; F3=010 -> illegal=1.
//  3 DIV (F7=0000001,F3=100), DIV_CYCLES=33 -> mdu_start 1 cycle, stall high exactly 32
//    cycles, next ADD captured on the cycle cnt==0.
//  4 MUL then MUL back-to-back, MUL_CYCLES=2 -> two mdu_start pulses 2 cycles apart.
//  5 flush 5 cycles into DIV -> mdu_abort pulse, stall low next cycle, ex_valid=0.
//  6 M_EXT=0, MUL encoding -> illegal=1, Operation=0010, stall never asserted.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings and FSM state type for the ALU control sequencer
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRL    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_SRA    = 4'b0111;
  localparam logic [3:0] OP_BEQ    = 4'b1000;
  localparam logic [3:0] OP_BNE    = 4'b1001;
  localparam logic [3:0] OP_PASS_B = 4'b1010;
  localparam logic [3:0] OP_SLT    = 4'b1100;
  localparam logic [3:0] OP_BGE    = 4'b1101;
  localparam logic [3:0] OP_SLTU   = 4'b1110;
  localparam logic [3:0] OP_BGEU   = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/funct decode into ALU operation, RV32M flag, illegal flag
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [1:0] aluop,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic       rtype,
  output logic [3:0] operation,
  output logic       is_mdu,
  output logic       illegal
);

  always_comb begin
    operation = OP_ADD;
    is_mdu    = 1'b0;
    illegal   = 1'b0;
    case (aluop)
      ALUOP_MEM:  operation = OP_ADD;
      ALUOP_JUMP: operation = OP_PASS_B;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000: operation = OP_BEQ;
          3'b001: operation = OP_BNE;
          3'b100: operation = OP_SLT;
          3'b101: operation = OP_BGE;
          3'b110: operation = OP_SLTU;
          3'b111: operation = OP_BGEU;
          default: begin
            operation = OP_BEQ;
            illegal   = 1'b1;
          end
        endcase
      end
      default: begin
        if (rtype && funct7 == FUNCT7_MULDIV) begin
          // MDU result is muxed at writeback, so Operation stays ADD for M ops.
          is_mdu  = (M_EXT != 0);
          illegal = (M_EXT == 0);
        end else begin
          case (funct3)
            3'b000: operation = (rtype && funct7 == FUNCT7_ALT) ? OP_SUB : OP_ADD;
            3'b001: operation = OP_SLL;
            3'b010: operation = OP_SLT;
            3'b011: operation = OP_SLTU;
            3'b100: operation = OP_XOR;
            3'b101: begin
              if (funct7 == FUNCT7_BASE)     operation = OP_SRL;
              else if (funct7 == FUNCT7_ALT) operation = OP_SRA;
              else                           illegal   = 1'b1;
            end
            3'b110: operation = OP_OR;
            default: operation = OP_AND;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ID/EX ALU controller with fixed-latency MUL/DIV sequencing
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int M_EXT      = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic       id_rtype,
  input  logic [1:0] ALUOp,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  input  logic       flush,
  output logic       stall,
  output logic       ex_valid,
  output logic [3:0] Operation,
  output logic       ex_is_mdu,
  output logic [2:0] mdu_op,
  output logic       mdu_start,
  output logic       mdu_abort,
  output logic       illegal
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, load_cnt;
  logic [3:0]       dec_op;
  logic             dec_mdu, dec_illegal, capture;

  alu_op_decode #(.M_EXT(M_EXT)) u_decode (
    .aluop     (ALUOp),
    .funct7    (Funct7),
    .funct3    (Funct3),
    .rtype     (id_rtype),
    .operation (dec_op),
    .is_mdu    (dec_mdu),
    .illegal   (dec_illegal)
  );

  assign stall    = (state == ST_BUSY) && (cnt != '0);
  assign capture  = id_valid && !stall && !flush;
  assign load_cnt = Funct3[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (capture && dec_mdu && load_cnt != '0) begin
      state_next = ST_BUSY;
      cnt_next   = load_cnt;
    end else if (capture) begin
      // Single-cycle op (or N=1 MDU op) retires immediately.
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (state == ST_BUSY) begin
      if (cnt != '0) cnt_next   = cnt - CNT_W'(1);
      else           state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ex_valid  <= 1'b0;
      Operation <= OP_ADD;
      ex_is_mdu <= 1'b0;
      mdu_op    <= 3'b000;
      mdu_start <= 1'b0;
      mdu_abort <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ex_valid  <= capture;
      mdu_start <= capture && dec_mdu;
      mdu_abort <= flush && stall;
      if (capture) begin
        Operation <= dec_op;
        ex_is_mdu <= dec_mdu;
        mdu_op    <= Funct3;
        illegal   <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed self-checking bench for alu_control_seq
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       reset, id_valid, id_rtype, flush;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;

  logic       stall, ex_valid, ex_is_mdu, mdu_start, mdu_abort, illegal;
  logic [3:0] Operation;
  logic [2:0] mdu_op;

  logic       stall2, ex_valid2, ex_is_mdu2, mdu_start2, mdu_abort2, illegal2;
  logic [3:0] Operation2;
  logic [2:0] mdu_op2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_control_seq #(.M_EXT(1), .MUL_CYCLES(2), .DIV_CYCLES(33)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rtype(id_rtype),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .Operation(Operation),
    .ex_is_mdu(ex_is_mdu), .mdu_op(mdu_op), .mdu_start(mdu_start),
    .mdu_abort(mdu_abort), .illegal(illegal)
  );

  alu_control_seq #(.M_EXT(0), .MUL_CYCLES(2), .DIV_CYCLES(33)) dut_nom (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rtype(id_rtype),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .flush(flush),
    .stall(stall2), .ex_valid(ex_valid2), .Operation(Operation2),
    .ex_is_mdu(ex_is_mdu2), .mdu_op(mdu_op2), .mdu_start(mdu_start2),
    .mdu_abort(mdu_abort2), .illegal(illegal2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rt, input logic [1:0] op,
                       input logic [6:0] f7, input logic [2:0] f3);
    id_valid = v;
    id_rtype = rt;
    ALUOp    = op;
    Funct7   = f7;
    Funct3   = f3;
  endtask

  initial begin
    logic [3:0] br_op [8];
    logic       br_ill[8];
    int         stall_cnt;

    br_op  = '{4'h8, 4'h9, 4'h8, 4'h8, 4'hC, 4'hD, 4'hE, 4'hF};
    br_ill = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 7'h00, 3'b000);
    tick();
    tick();
    check("rst_stall", stall, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_operation", Operation, 4'b0010);
    check("rst_mdu_op", mdu_op, 0);
    check("rst_ex_is_mdu", ex_is_mdu, 0);
    check("rst_mdu_start", mdu_start, 0);
    check("rst_mdu_abort", mdu_abort, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b0;

    // SUB only for R-type; ADDI with the same bit pattern stays ADD
    drive(1'b1, 1'b1, 2'b10, 7'b0100000, 3'b000);
    tick();
    check("sub_op", Operation, 4'b0110);
    check("sub_valid", ex_valid, 1);
    check("sub_illegal", illegal, 0);
    drive(1'b1, 1'b0, 2'b10, 7'b0100000, 3'b000);
    tick();
    check("addi_op", Operation, 4'b0010);

    drive(1'b1, 1'b1, 2'b10, 7'b0100000, 3'b101);
    tick();
    check("sra_op", Operation, 4'b0111);
    drive(1'b1, 1'b1, 2'b10, 7'b0000010, 3'b101);
    tick();
    check("shift_bad_f7_illegal", illegal, 1);
    check("shift_bad_f7_op", Operation, 4'b0010);
    drive(1'b1, 1'b0, 2'b00, 7'h7F, 3'b111);
    tick();
    check("mem_op", Operation, 4'b0010);
    check("mem_illegal", illegal, 0);
    drive(1'b1, 1'b0, 2'b11, 7'h00, 3'b000);
    tick();
    check("jump_op", Operation, 4'b1010);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 2'b01, 7'h00, 3'(i));
      tick();
      check($sformatf("branch_op_f3_%0d", i), Operation, br_op[i]);
      check($sformatf("branch_ill_f3_%0d", i), illegal, br_ill[i]);
    end

    // DIV: stall exactly 32 cycles, the waiting ADD captured on the cnt==0 cycle
    drive(1'b1, 1'b1, 2'b10, 7'b0000001, 3'b100);
    tick();
    check("div_start", mdu_start, 1);
    check("div_is_mdu", ex_is_mdu, 1);
    check("div_mdu_op", mdu_op, 3'b100);
    check("div_stall", stall, 1);
    drive(1'b1, 1'b1, 2'b10, 7'b0000000, 3'b000);
    tick();
    check("div_start_one_cycle", mdu_start, 0);
    stall_cnt = 1;
    for (int i = 0; i < 40 && stall; i++) begin
      stall_cnt++;
      tick();
    end
    check("div_stall_cycles", stall_cnt, 32);
    tick();
    check("div_next_valid", ex_valid, 1);
    check("div_next_op", Operation, 4'b0010);
    check("div_next_not_mdu", ex_is_mdu, 0);
    drive(1'b0, 1'b0, 2'b00, 7'h00, 3'b000);
    tick();

    // back-to-back MUL
    drive(1'b1, 1'b1, 2'b10, 7'b0000001, 3'b000);
    tick();
    check("mul1_start", mdu_start, 1);
    check("mul1_stall", stall, 1);
    tick();
    check("mul_gap_start", mdu_start, 0);
    check("mul_gap_stall", stall, 0);
    tick();
    check("mul2_start", mdu_start, 1);
    check("mul2_stall", stall, 1);
    tick();
    check("mul2_done_stall", stall, 0);
    drive(1'b0, 1'b0, 2'b00, 7'h00, 3'b000);
    tick();
    check("mul_idle_start", mdu_start, 0);

    // flush 5 cycles into a DIV
    drive(1'b1, 1'b1, 2'b10, 7'b0000001, 3'b101);
    tick();
    drive(1'b0, 1'b0, 2'b00, 7'h00, 3'b000);
    for (int i = 0; i < 5; i++) tick();
    check("div_busy_before_flush", stall, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_abort", mdu_abort, 1);
    check("flush_stall", stall, 0);
    check("flush_ex_valid", ex_valid, 0);
    tick();
    check("abort_one_cycle", mdu_abort, 0);

    // flush on the cnt==0 cycle: no abort, and flush beats a valid capture
    drive(1'b1, 1'b1, 2'b10, 7'b0000001, 3'b000);
    tick();
    tick();
    check("mul_cnt0_stall", stall, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_cnt0_no_abort", mdu_abort, 0);
    check("flush_beats_capture", ex_valid, 0);
    check("flush_no_start", mdu_start, 0);
    drive(1'b0, 1'b0, 2'b00, 7'h00, 3'b000);
    tick();

    // reset mid-BUSY: no abort pulse
    drive(1'b1, 1'b1, 2'b10, 7'b0000001, 3'b110);
    tick();
    drive(1'b0, 1'b0, 2'b00, 7'h00, 3'b000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy_abort", mdu_abort, 0);
    check("rst_busy_stall", stall, 0);
    check("rst_busy_valid", ex_valid, 0);
    tick();
    check("rst_busy_abort_after", mdu_abort, 0);

    // M_EXT=0: MUL encoding is illegal and never stalls
    drive(1'b1, 1'b1, 2'b10, 7'b0000001, 3'b000);
    tick();
    check("nom_illegal", illegal2, 1);
    check("nom_op", Operation2, 4'b0010);
    check("nom_is_mdu", ex_is_mdu2, 0);
    check("nom_start", mdu_start2, 0);
    check("nom_stall", stall2, 0);
    drive(1'b0, 1'b0, 2'b00, 7'h00, 3'b000);
    tick();
    check("nom_stall_after", stall2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
